// File: rtl/gb_timer.sv
// DMG timer: 16-bit system counter (DIV), TIMA/TMA/TAC at FF04-FF07,
// falling-edge TIMA clocking, delayed TMA reload and timer interrupt pulse.
module gb_timer #(
  parameter int unsigned TICKS_PER_MCYCLE = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tick_in,
  input  logic [1:0]  addr_in,
  input  logic        wr_in,
  input  logic [7:0]  wr_data_in,
  output logic [7:0]  rd_data_out,
  output logic [15:0] sys_count_out,
  output logic        irq_out
);

  localparam int unsigned CNT_W = (TICKS_PER_MCYCLE > 1) ? $clog2(TICKS_PER_MCYCLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MCYCLE - 1);

  typedef enum logic {ST_RUN, ST_OVF} state_t;

  state_t           state;
  logic [15:0]      sys;
  logic [7:0]       tima;
  logic [7:0]       tma;
  logic [2:0]       tac;
  logic             sig_q;
  logic [CNT_W-1:0] ovf_cnt;

  logic       wr_div, wr_tima, wr_tma, wr_tac;
  logic       tap, sig, fall;
  logic [7:0] tma_now;

  assign wr_div  = wr_in && (addr_in == 2'd0);
  assign wr_tima = wr_in && (addr_in == 2'd1);
  assign wr_tma  = wr_in && (addr_in == 2'd2);
  assign wr_tac  = wr_in && (addr_in == 2'd3);

  // Tap select from the registered TAC and counter
  always_comb begin
    tap = 1'b0;
    unique case (tac[1:0])
      2'b00: tap = sys[9];
      2'b01: tap = sys[3];
      2'b10: tap = sys[5];
      2'b11: tap = sys[7];
    endcase
  end

  assign sig     = tac[2] & tap;
  assign fall    = sig_q & ~sig;
  // Reload sees a TMA value written on the same clk
  assign tma_now = wr_tma ? wr_data_in : tma;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ST_RUN;
      sys     <= 16'd0;
      tima    <= 8'd0;
      tma     <= 8'd0;
      tac     <= 3'd0;
      sig_q   <= 1'b0;
      ovf_cnt <= '0;
      irq_out <= 1'b0;
    end else begin
      irq_out <= 1'b0;
      sig_q   <= sig;

      if (wr_div)
        sys <= 16'd0;
      else if (tick_in)
        sys <= sys + 16'd1;

      if (wr_tma)
        tma <= wr_data_in;
      if (wr_tac)
        tac <= wr_data_in[2:0];

      case (state)
        ST_RUN: begin
          if (wr_tima) begin
            tima <= wr_data_in;
          end else if (fall) begin
            if (tima == 8'hFF) begin
              tima    <= 8'h00;
              ovf_cnt <= '0;
              state   <= ST_OVF;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        ST_OVF: begin
          // A CPU write to TIMA during the delay cancels the reload
          if (wr_tima) begin
            tima  <= wr_data_in;
            state <= ST_RUN;
          end else if (tick_in) begin
            if (ovf_cnt == CNT_LAST) begin
              tima    <= tma_now;
              irq_out <= 1'b1;
              state   <= ST_RUN;
            end else begin
              ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    rd_data_out = 8'h00;
    unique case (addr_in)
      2'd0: rd_data_out = sys[15:8];
      2'd1: rd_data_out = tima;
      2'd2: rd_data_out = tma;
      2'd3: rd_data_out = {5'b11111, tac};
    endcase
  end

  assign sys_count_out = sys;

endmodule

// File: tb/tb_gb_timer.sv
// Directed plus randomized bench for gb_timer against a tick-budget model.
module tb_gb_timer;

  localparam int unsigned TPM = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, tick_in, wr_in;
  logic [1:0]  addr_in;
  logic [7:0]  wr_data_in;
  logic [7:0]  rd_data_out;
  logic [15:0] sys_count_out;
  logic        irq_out;

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;

  gb_timer #(.TICKS_PER_MCYCLE(TPM)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .tick_in       (tick_in),
    .addr_in       (addr_in),
    .wr_in         (wr_in),
    .wr_data_in    (wr_data_in),
    .rd_data_out   (rd_data_out),
    .sys_count_out (sys_count_out),
    .irq_out       (irq_out)
  );

  always #10 clk_in = ~clk_in;

  // Reference model: plain integers, reload tracked as remaining tick budget
  int m_sys, m_tima, m_tma, m_tac, m_prev_sig, m_left, m_irq;
  bit m_ovf;
  int taps[4] = '{9, 3, 5, 7};

  function automatic void model_reset();
    m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_prev_sig = 0;
    m_ovf = 0; m_left = 0; m_irq = 0;
  endfunction

  function automatic void model_step(input bit rst, input bit tick, input bit wr,
                                     input int addr, input int data);
    int sig;
    bit fall;
    if (rst) begin
      model_reset();
      return;
    end
    sig  = ((m_tac >> 2) & 1) & ((m_sys >> taps[m_tac & 3]) & 1);
    fall = (m_prev_sig == 1) && (sig == 0);
    m_prev_sig = sig;
    m_irq = 0;
    if (m_ovf) begin
      if (wr && addr == 1) begin
        m_tima = data;
        m_ovf = 0;
      end else if (tick) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_tima = (wr && addr == 2) ? data : m_tma;
          m_ovf = 0;
          m_irq = 1;
        end
      end
    end else begin
      if (wr && addr == 1) m_tima = data;
      else if (fall) begin
        if (m_tima == 255) begin
          m_tima = 0;
          m_ovf = 1;
          m_left = TPM;
        end else m_tima = m_tima + 1;
      end
    end
    if (wr && addr == 0) m_sys = 0;
    else if (tick) m_sys = (m_sys + 1) % 65536;
    if (wr && addr == 2) m_tma = data;
    if (wr && addr == 3) m_tac = data & 7;
  endfunction

  function automatic int model_rd(input int a);
    case (a)
      0: return (m_sys >> 8) & 255;
      1: return m_tima;
      2: return m_tma;
      default: return 248 | m_tac;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clk: drive inputs, advance model, then compare every visible register
  task automatic step(input bit rst, input bit tick, input bit wr,
                      input logic [1:0] addr, input logic [7:0] data);
    rst_in = rst; tick_in = tick; wr_in = wr; addr_in = addr; wr_data_in = data;
    @(posedge clk_in);
    model_step(rst, tick, wr, int'(addr), int'(data));
    #1;
    rst_in = 1'b0; tick_in = 1'b0; wr_in = 1'b0;
    check("sys", sys_count_out, 16'(m_sys));
    check("irq", 16'(irq_out), 16'(m_irq));
    if (irq_out === 1'b1) irq_seen++;
    for (int a = 0; a < 4; a++) begin
      addr_in = 2'(a);
      #1;
      check($sformatf("rd%0d", a), 16'(rd_data_out), 16'(model_rd(a)));
    end
    @(negedge clk_in);
  endtask

  task automatic peek(input logic [1:0] a, input string tag, input logic [7:0] exp);
    addr_in = a;
    #1;
    check(tag, 16'(rd_data_out), 16'(exp));
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    rst_in = 1'b1; tick_in = 1'b0; wr_in = 1'b0; addr_in = 2'd0; wr_data_in = 8'h00;
    model_reset();
    @(negedge clk_in);

    // Reset then free-run
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    peek(2'd3, "rst_tac", 8'hF8);
    peek(2'd0, "rst_div", 8'h00);
    peek(2'd1, "rst_tima", 8'h00);
    ticks(256);
    peek(2'd0, "div_256", 8'h01);
    peek(2'd1, "tima_idle", 8'h00);
    check("irq_idle", 16'(irq_seen), 16'd0);

    // Fastest rate
    wr_reg(2'd3, 8'h05);
    wr_reg(2'd1, 8'h00);
    ticks(16);
    idle();
    peek(2'd1, "fast_16", 8'h01);
    ticks(1024);
    idle();
    peek(2'd1, "fast_1040", 8'h41);

    // Overflow and reload
    wr_reg(2'd2, 8'hAB);
    wr_reg(2'd1, 8'hFF);
    irq_seen = 0;
    ticks(17);
    peek(2'd1, "ovf_zero", 8'h00);
    ticks(3);
    peek(2'd1, "ovf_hold", 8'h00);
    ticks(1);
    peek(2'd1, "reload", 8'hAB);
    ticks(19);
    peek(2'd1, "post_reload", 8'hAC);
    check("irq_once", 16'(irq_seen), 16'd1);

    // Cancelled reload
    wr_reg(2'd1, 8'hFF);
    irq_seen = 0;
    ticks(11);
    wr_reg(2'd1, 8'h10);
    ticks(4);
    peek(2'd1, "cancel", 8'h10);
    check("irq_cancel", 16'(irq_seen), 16'd0);

    // Reset mid-OVF
    wr_reg(2'd1, 8'hFF);
    ticks(11);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    ticks(8);
    check("irq_rst_ovf", 16'(irq_seen), 16'd0);
    peek(2'd1, "rst_ovf_tima", 8'h00);

    // DIV-write glitch
    wr_reg(2'd3, 8'h04);
    ticks(504);
    wr_reg(2'd1, 8'h05);
    wr_reg(2'd0, 8'h00);
    idle();
    peek(2'd1, "div_glitch", 8'h06);
    peek(2'd0, "div_cleared", 8'h00);

    // Disable glitch
    wr_reg(2'd3, 8'h05);
    ticks(8);
    wr_reg(2'd1, 8'h20);
    wr_reg(2'd3, 8'h01);
    idle();
    peek(2'd1, "dis_glitch", 8'h21);
    ticks(64);
    peek(2'd1, "dis_hold", 8'h21);

    // Randomized traffic, biased toward overflow and fast taps
    for (int i = 0; i < 4000; i++) begin
      bit r, t, w;
      logic [1:0] a;
      logic [7:0] d;
      r = ($urandom_range(0, 499) == 0);
      t = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 9) == 0);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if (a == 2'd1 && $urandom_range(0, 2) == 0) d = 8'hFF;
      if (a == 2'd3 && $urandom_range(0, 1) == 0) d = 8'h05;
      step(r, t, w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
